// File: rtl/lcd_pkg.sv
// Shared LCD line constants, hex-to-ASCII helper and entry FSM state type.
package lcd_pkg;

    localparam int unsigned CHAR_W   = 9;
    localparam int unsigned LINE_LEN = 16;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned CURSOR_W = 4;
    localparam int unsigned DATA_W   = LINE_LEN * NIBBLE_W;
    localparam int unsigned CHARS_W  = LINE_LEN * CHAR_W;

    localparam logic [CHAR_W-1:0] BLANK_CHAR       = 9'h12D;
    localparam logic [7:0]        ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0]        ASCII_ALPHA_BASE = 8'h37;

    typedef enum logic {
        ST_EDIT = 1'b0,
        ST_FULL = 1'b1
    } entry_state_e;

    typedef struct packed {
        logic clear;
        logic back;
        logic enter;
    } key_events_t;

    // {RS=1, ASCII} for a hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
    function automatic logic [CHAR_W-1:0] hex_char(input logic [NIBBLE_W-1:0] nib);
        logic [7:0] base;
        base = (nib < 4'd10) ? ASCII_DIGIT_BASE : ASCII_ALPHA_BASE;
        return {1'b1, base + 8'(nib)};
    endfunction

endpackage

// File: rtl/hex_entry_buffer_if.sv
// Bundle of the hex entry buffer's switch/key inputs and display outputs.
interface hex_entry_buffer_if;
    import lcd_pkg::*;

    logic [NIBBLE_W-1:0] nibble;
    logic                key_enter_n;
    logic                key_back_n;
    logic                key_clear_n;
    logic [DATA_W-1:0]   data;
    logic [CHARS_W-1:0]  chars;
    logic [CURSOR_W-1:0] cursor;
    logic                full;
    logic                valid;

    modport master (
        output nibble, key_enter_n, key_back_n, key_clear_n,
        input  data, chars, cursor, full, valid
    );

    modport slave (
        input  nibble, key_enter_n, key_back_n, key_clear_n,
        output data, chars, cursor, full, valid
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push-button; emits a one-cycle press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Until a full released interval is seen after reset, a held key cannot register a press.
    always_comb begin
        sync_d   = {sync_q[0], key_ni};
        stable_d = stable_q;
        armed_d  = armed_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (!armed_q) begin
            if (sync_q[1]) begin
                if (cnt_q == CNT_LAST) begin
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                press_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/hex_entry_buffer.sv
// Sixteen-digit hex entry buffer driven by ENTER/BACK/CLEAR keys, with LCD character output.
module hex_entry_buffer
    import lcd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [NIBBLE_W-1:0] iNIBBLE,
    input  logic                iKEY_ENTER,
    input  logic                iKEY_BACK,
    input  logic                iKEY_CLEAR,
    output logic [DATA_W-1:0]   oDATA,
    output logic [CHARS_W-1:0]  oCHARS,
    output logic [CURSOR_W-1:0] oCURSOR,
    output logic                oFULL,
    output logic                oVALID
);

    localparam logic [CURSOR_W-1:0] LAST_POS = CURSOR_W'(LINE_LEN - 1);

    logic        enter_p, back_p, clear_p;
    key_events_t ev;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk_i(iCLK), .rst_ni(iRST_N), .key_ni(iKEY_ENTER), .press_o(enter_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk_i(iCLK), .rst_ni(iRST_N), .key_ni(iKEY_BACK), .press_o(back_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk_i(iCLK), .rst_ni(iRST_N), .key_ni(iKEY_CLEAR), .press_o(clear_p)
    );

    assign ev = '{clear: clear_p, back: back_p, enter: enter_p};

    logic [NIBBLE_W-1:0] nib_meta_q, nib_sync_q;
    entry_state_e        state_q, state_d;
    logic [CURSOR_W-1:0] cursor_q, cursor_d, cursor_prev;
    logic [NIBBLE_W-1:0] digit_q [LINE_LEN];
    logic [NIBBLE_W-1:0] digit_d [LINE_LEN];
    logic [CHAR_W-1:0]   char_q  [LINE_LEN];
    logic [CHAR_W-1:0]   char_d  [LINE_LEN];
    logic                full_q, full_d;
    logic                valid_q, valid_d;

    assign cursor_prev = cursor_q - CURSOR_W'(1);

    // Only the highest-priority event (CLEAR > BACK > ENTER) acts in a given cycle.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        digit_d  = digit_q;
        char_d   = char_q;
        full_d   = full_q;
        valid_d  = 1'b0;
        if (ev.clear) begin
            state_d  = ST_EDIT;
            cursor_d = '0;
            full_d   = 1'b0;
            for (int i = 0; i < LINE_LEN; i++) begin
                digit_d[i] = '0;
                char_d[i]  = BLANK_CHAR;
            end
        end else if (ev.back) begin
            if (state_q == ST_FULL) begin
                state_d           = ST_EDIT;
                full_d            = 1'b0;
                digit_d[LAST_POS] = '0;
                char_d[LAST_POS]  = BLANK_CHAR;
            end else if (cursor_q != '0) begin
                cursor_d             = cursor_prev;
                digit_d[cursor_prev] = '0;
                char_d[cursor_prev]  = BLANK_CHAR;
            end
        end else if (ev.enter && (state_q == ST_EDIT)) begin
            digit_d[cursor_q] = nib_sync_q;
            char_d[cursor_q]  = hex_char(nib_sync_q);
            if (cursor_q == LAST_POS) begin
                state_d = ST_FULL;
                full_d  = 1'b1;
                valid_d = 1'b1;
            end else begin
                cursor_d = cursor_q + CURSOR_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            nib_meta_q <= '0;
            nib_sync_q <= '0;
            state_q    <= ST_EDIT;
            cursor_q   <= '0;
            digit_q    <= '{default: '0};
            char_q     <= '{default: BLANK_CHAR};
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            nib_meta_q <= iNIBBLE;
            nib_sync_q <= nib_meta_q;
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            digit_q    <= digit_d;
            char_q     <= char_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
        end
    end

    // Position 0 occupies the most significant slot of both packed outputs.
    for (genvar g = 0; g < LINE_LEN; g++) begin : g_out
        assign oDATA[DATA_W-1-g*NIBBLE_W -: NIBBLE_W] = digit_q[g];
        assign oCHARS[CHARS_W-1-g*CHAR_W -: CHAR_W]   = char_q[g];
    end

    assign oCURSOR = cursor_q;
    assign oFULL   = full_q;
    assign oVALID  = valid_q;

endmodule

// File: doc/hex_entry_buffer.md
HEX_ENTRY_BUFFER -- requirements
Module: hex_entry_buffer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000 (5 ms at 50 MHz): number of consecutive stable synchronized samples before a key change is accepted.
REQ-002 SHALL have port iCLK, input, 1, the single clock for all logic.
REQ-003 SHALL have port iRST_N, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port iNIBBLE, input, 4, hex digit from switches; asynchronous to iCLK.
REQ-005 SHALL have port iKEY_ENTER, input, 1, raw active-low push-button that appends iNIBBLE.
REQ-006 SHALL have port iKEY_BACK, input, 1, raw active-low push-button that deletes the last digit.
REQ-007 SHALL have port iKEY_CLEAR, input, 1, raw active-low push-button that empties the buffer.
REQ-008 SHALL have port oDATA, output, 64, entered value; the first digit entered is in bits [63:60].
REQ-009 SHALL have port oCHARS, output, 144, 16 LCD character words of 9 bits {RS, ASCII}; character 0 is in bits [143:135].
REQ-010 SHALL have port oCURSOR, output, 4, index of the next position to fill.
REQ-011 SHALL have port oFULL, output, 1, high while all 16 digits are entered.
REQ-012 SHALL have port oVALID, output, 1, one-cycle pulse when the 16th digit is entered.

Function
REQ-013 SHALL pass each key through a two-flop synchronizer and then a debouncer, yielding a press pulse of exactly one cycle per debounced high-to-low transition.
REQ-014 SHALL sample iNIBBLE through a two-flop synchronizer and use the synchronized value on the cycle the ENTER pulse occurs.
REQ-015 SHALL implement a two-state FSM: EDIT (cursor 0..15, not full) and FULL.
REQ-016 SHALL apply event priority CLEAR > BACK > ENTER when pulses coincide; only the highest-priority event takes effect.
REQ-017 SHALL, on ENTER in EDIT, write the nibble to position oCURSOR and increment the cursor; at cursor 15, the FSM SHALL go to FULL, hold oCURSOR at 15, set oFULL and pulse oVALID.
REQ-018 SHALL ignore ENTER in FULL.
REQ-019 SHALL, on BACK in EDIT with cursor > 0, decrement the cursor and set that position's nibble to 0 and its character to the blank code.
REQ-020 SHALL ignore BACK in EDIT with cursor 0.
REQ-021 SHALL, on BACK in FULL, blank position 15, go to EDIT with cursor 15, and drop oFULL.
REQ-022 SHALL, on CLEAR in any state, set oDATA to 0, blank all characters, set the cursor to 0, drop oFULL, and not pulse oVALID.
REQ-023 SHALL encode each filled character as {1'b1, ASCII}: nibbles 0-9 map to 0x30-0x39 and A-F map to 0x41-0x46.
REQ-024 SHALL encode each unfilled character as 9'h12D (RS=1, '-').
REQ-025 SHALL register all outputs; oDATA, oCHARS, oCURSOR and oFULL SHALL update on the clock edge following the press pulse, and all of them on that same edge.
REQ-026 SHALL make oVALID high on the same cycle oFULL first rises.
REQ-027 SHALL produce no further pulse while a key is held, and no pulse on release.
REQ-028 SHALL reject any key glitch shorter than DEBOUNCE_CYCLES.

Reset
REQ-029 SHALL, while iRST_N is low at a clock edge, set oDATA=0, all 16 characters of oCHARS=9'h12D, oCURSOR=0, oFULL=0, oVALID=0, and the FSM to EDIT.
REQ-030 SHALL also clear the synchronizers to 1 (released), the debounce counters to 0, and the debounced key states to released.
REQ-031 SHALL treat a key held low through reset deassertion as requiring release and a new press before it takes effect.
REQ-032 SHALL, when reset is asserted mid-entry, discard all partial entry and produce no output pulse.

Structure
REQ-033 SHALL place the following in shared package lcd_pkg: character width (9), line length (16), the blank code 9'h12D, the ASCII bases 0x30 and 0x37 (letter offset), and the FSM state type.
REQ-034 SHALL instantiate sub-module key_debounce three times, one per key; key_debounce contains the synchronizer, the counter sized by DEBOUNCE_CYCLES, and the press-pulse generator.
REQ-035 SHALL make the oCHARS format directly compatible with the team's 144-bit LCD line inputs.

Verification (DEBOUNCE_CYCLES=4)
REQ-036 SHALL test reset: after reset, oCHARS = sixteen copies of 9'h12D, oDATA=0, oCURSOR=0, and oFULL=0.
REQ-037 SHALL test entry: iNIBBLE=0xA followed by an ENTER press held 10 cycles gives exactly one entry, so oDATA[63:60]=0xA, char0=9'h141, oCURSOR=1.
REQ-038 SHALL test full entry: entering the digits 0..F gives oDATA=0x0123456789ABCDEF, char15=9'h146, oFULL=1, and one oVALID pulse; a 17th ENTER leaves all outputs unchanged.
REQ-039 SHALL test BACK from FULL: oCURSOR=15, oFULL=0, char15=9'h12D, and oDATA[3:0]=0.
REQ-040 SHALL test simultaneous keys: CLEAR and ENTER pressed in the same cycle with 5 digits entered give oCURSOR=0 and oDATA=0, with no entry.
REQ-041 SHALL test glitch rejection: a 2-cycle low glitch on ENTER produces no change; and an iRST_N low pulse after 7 digits restores the reset values of REQ-029.
